preg_free_list_ctrl: RTL and testbench

Manages the pool of free physical scalar registers for the rename stage. It is a multi-ported circular queue: each cycle the rename lanes pop up to `POP_WIDTH` free register numbers and the commit lanes push up to `PUSH_WIDTH` released numbers. After reset it runs a self-initialisation sequence that loads the non-architectural registers. It sits between rename (allocation) and commit/recovery (release) and enforces underflow and overflow protection.

---
 rtl/preg_free_list_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_preg_free_list_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/preg_free_list_ctrl.sv
// preg_free_list_ctrl
//   Free list of physical scalar registers for the rename stage. It is a
//   circular queue with POP_WIDTH allocation lanes and PUSH_WIDTH release
//   lanes. After reset it loads INIT_BASE .. INIT_BASE+ENTRY_NUM-1, one entry
//   per clock (INIT state). It then serves pops and pushes (RUN state).
//
//   Ports
//     clk, rst_n    : clock; asynchronous active-low reset
//     pop           : per-lane allocation request
//     popNum        : per-lane allocated register number, combinational, 0 while !ready
//     push, pushNum : per-lane release request and released register number
//     ready         : decode of the FSM state register (1 = RUN, 0 = INIT)
//     count         : number of free entries currently queued
//     allocatable   : ready && count >= POP_WIDTH
//     errUnderflow, errOverflow, errDup : sticky error flags, cleared by reset only
//
//   Handshake: a request lane is valid when its bit is high. There is no
//   ready/back-pressure path. A pop group larger than count is rejected as a
//   whole. A push group that would exceed ENTRY_NUM is also rejected as a
//   whole. Either rejection raises the matching sticky flag.
//
//   Optional feature macro: RSD_FREE_LIST_DUP_CHECK_EN
//     Defined: an isFree bitmap drops push lanes that release an already-free
//     number, or that repeat an earlier lane in the same cycle. Each such lane
//     raises errDup.
//     Undefined: errDup is tied to 0 and duplicate numbers are queued.
module preg_free_list_ctrl #(
    parameter int ENTRY_NUM  = 32,
    parameter int INIT_BASE  = 32,
    parameter int REG_W      = 6,
    parameter int POP_WIDTH  = 2,
    parameter int PUSH_WIDTH = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [POP_WIDTH-1:0]             pop,
    output logic [POP_WIDTH-1:0][REG_W-1:0]  popNum,
    input  logic [PUSH_WIDTH-1:0]            push,
    input  logic [PUSH_WIDTH-1:0][REG_W-1:0] pushNum,
    output logic                             ready,
    output logic [$clog2(ENTRY_NUM):0]       count,
    output logic                             allocatable,
    output logic                             errUnderflow,
    output logic                             errOverflow,
    output logic                             errDup
);
    localparam int PTR_W = $clog2(ENTRY_NUM);
    localparam int CNT_W = PTR_W + 1;
    // Wide enough for count + pushes without wrapping in the overflow test.
    localparam int SUM_W = $clog2(ENTRY_NUM + POP_WIDTH + PUSH_WIDTH + 1) + 1;
    localparam logic [SUM_W-1:0] SUM_ONE  = SUM_W'(1);
    localparam logic [SUM_W-1:0] SUM_FULL = SUM_W'(ENTRY_NUM);
    localparam logic [SUM_W-1:0] SUM_POPW = SUM_W'(POP_WIDTH);

    typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_e;

    state_e                           state_q, state_d;
    logic [PTR_W-1:0]                 head_q, head_d, tail_q, tail_d, init_q, init_d;
    logic [CNT_W-1:0]                 count_q, count_d;
    logic                             under_q, under_d, over_q, over_d;
    logic [REG_W-1:0]                 mem [ENTRY_NUM];
    logic [REG_W-1:0]                 init_val;
    logic [POP_WIDTH-1:0][PTR_W-1:0]  pop_addr;
    logic [PUSH_WIDTH-1:0][PTR_W-1:0] push_addr;
    logic [PUSH_WIDTH-1:0]            push_v;
    logic [SUM_W-1:0]                 n_pop, n_push, pop_acc, push_acc, count_ext;
    logic                             pop_go, push_go;

    assign count_ext = SUM_W'(count_q);
    assign init_val  = REG_W'(INIT_BASE) + REG_W'(init_q);

    // Pop lane compaction: lane i reads head + number of active lanes below it.
    always_comb begin
        n_pop = '0;
        for (int i = 0; i < POP_WIDTH; i++) begin
            pop_addr[i] = head_q + n_pop[PTR_W-1:0];
            if (pop[i]) n_pop = n_pop + SUM_ONE;
        end
    end

    assign pop_go  = (state_q == S_RUN) && (n_pop <= count_ext);
    assign pop_acc = pop_go ? n_pop : '0;

    // Push lane compaction over surviving lanes only (dropped duplicates leave no hole).
    always_comb begin
        n_push = '0;
        for (int i = 0; i < PUSH_WIDTH; i++) begin
            push_addr[i] = tail_q + n_push[PTR_W-1:0];
            if (push_v[i]) n_push = n_push + SUM_ONE;
        end
    end

    // Overflow is judged after this cycle's accepted pops have freed space.
    assign push_go  = (state_q == S_RUN) && ((count_ext - pop_acc + n_push) <= SUM_FULL);
    assign push_acc = push_go ? n_push : '0;

    always_comb begin
        popNum = '0;
        for (int i = 0; i < POP_WIDTH; i++) begin
            popNum[i] = ready ? mem[pop_addr[i]] : '0;
        end
    end

`ifdef RSD_FREE_LIST_DUP_CHECK_EN
    localparam int MAP_N = 1 << REG_W;
    logic [MAP_N-1:0] is_free_q, is_free_d, popped;
    logic             dup_hit, dup_q;

    always_comb begin
        popped = '0;
        for (int i = 0; i < POP_WIDTH; i++) begin
            if (pop_go && pop[i]) popped[popNum[i]] = 1'b1;
        end
        // A number leaving the queue this cycle no longer counts as free, so
        // it may be released again in the same cycle.
        push_v  = '0;
        dup_hit = 1'b0;
        for (int i = 0; i < PUSH_WIDTH; i++) begin
            push_v[i] = push[i];
            if (push[i] && is_free_q[pushNum[i]] && !popped[pushNum[i]]) push_v[i] = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (push[i] && push[j] && (pushNum[j] == pushNum[i])) push_v[i] = 1'b0;
            end
            if (push[i] && !push_v[i]) dup_hit = 1'b1;
        end
        is_free_d = is_free_q;
        if (state_q == S_INIT) begin
            is_free_d[init_val] = 1'b1;
        end else begin
            is_free_d = is_free_d & ~popped;
            for (int i = 0; i < PUSH_WIDTH; i++) begin
                if (push_go && push_v[i]) is_free_d[pushNum[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_free_q <= '0;
            dup_q     <= 1'b0;
        end else begin
            is_free_q <= is_free_d;
            if (state_q == S_RUN && dup_hit) dup_q <= 1'b1;
        end
    end

    assign errDup = dup_q;
`else
    assign push_v = push;
    assign errDup = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        init_d  = init_q;
        count_d = count_q;
        under_d = under_q;
        over_d  = over_q;
        if (state_q == S_INIT) begin
            tail_d  = tail_q + PTR_W'(1);
            init_d  = init_q + PTR_W'(1);
            count_d = count_q + CNT_W'(1);
            if (|pop)  under_d = 1'b1;
            if (|push) over_d  = 1'b1;
            if (init_q == PTR_W'(ENTRY_NUM - 1)) state_d = S_RUN;
        end else begin
            if (!pop_go)  under_d = 1'b1;
            if (!push_go) over_d  = 1'b1;
            head_d  = head_q + pop_acc[PTR_W-1:0];
            tail_d  = tail_q + push_acc[PTR_W-1:0];
            count_d = CNT_W'(count_ext - pop_acc + push_acc);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            head_q  <= '0;
            tail_q  <= '0;
            init_q  <= '0;
            count_q <= '0;
            under_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            init_q  <= init_d;
            count_q <= count_d;
            under_q <= under_d;
            over_q  <= over_d;
        end
    end

    // Storage is deliberately not reset; INIT rewrites every entry.
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            mem[tail_q] <= init_val;
        end else if (push_go) begin
            for (int i = 0; i < PUSH_WIDTH; i++) begin
                if (push_v[i]) mem[push_addr[i]] <= pushNum[i];
            end
        end
    end

    assign ready        = (state_q == S_RUN);
    assign count        = count_q;
    assign allocatable  = ready && (count_ext >= SUM_POPW);
    assign errUnderflow = under_q;
    assign errOverflow  = over_q;

endmodule

// File: tb/tb_preg_free_list_ctrl.sv
module tb_preg_free_list_ctrl;
  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      pop;
  logic [1:0][5:0] pop_num;
  logic [1:0]      push;
  logic [1:0][5:0] push_num;
  logic            ready;
  logic [5:0]      count;
  logic            allocatable;
  logic            err_underflow;
  logic            err_overflow;
  logic            err_dup;

  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];
  logic [5:0] e0, e1;

  always #5 clk = ~clk;

  preg_free_list_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .pop(pop), .popNum(pop_num),
    .push(push), .pushNum(push_num),
    .ready(ready), .count(count), .allocatable(allocatable),
    .errUnderflow(err_underflow), .errOverflow(err_overflow), .errDup(err_dup)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pop = '0;
    push = '0;
    push_num = '0;
  endtask

  task automatic reset_and_init();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (32) step();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_count", count, 0);
    chk("rst_alloc", allocatable, 0);
    chk("rst_popnum", pop_num, 0);
    chk("rst_under", err_underflow, 0);
    chk("rst_over", err_overflow, 0);
    chk("rst_dup", err_dup, 0);

    // Init timing
    step();
    rst_n = 1'b1;
    repeat (31) step();
    chk("init_ready_lo", ready, 0);
    chk("init_count31", count, 31);
    step();
    chk("init_ready_hi", ready, 1);
    chk("init_count32", count, 32);
    chk("init_alloc", allocatable, 1);
    pop = 2'b11;
    #1;
    chk("pop11_lane0", pop_num[0], 32);
    chk("pop11_lane1", pop_num[1], 33);
    step();
    idle();
    chk("pop11_count", count, 30);

    // Compaction
    reset_and_init();
    pop = 2'b10;
    #1;
    chk("cmp_lane1", pop_num[1], 32);
    step();
    pop = 2'b00;
    chk("cmp_count", count, 31);
    pop = 2'b01;
    #1;
    chk("cmp_next", pop_num[0], 33);
    step();
    idle();
    chk("cmp_count30", count, 30);

    // Drain then underflow
    pop = 2'b11;
    repeat (15) step();
    idle();
    chk("drain_count", count, 0);
    chk("drain_alloc", allocatable, 0);
    chk("drain_under", err_underflow, 0);
    pop = 2'b01;
    step();
    idle();
    chk("uf_flag", err_underflow, 1);
    chk("uf_count", count, 0);
    chk("uf_over", err_overflow, 0);

    // Simultaneous pop and push
    reset_and_init();
    pop = 2'b11;
    repeat (15) step();
    pop = 2'b01;
    step();
    idle();
    chk("sim_count1", count, 1);
    chk("sim_alloc", allocatable, 0);
    pop = 2'b01;
    push = 2'b01;
    push_num[0] = 6'd5;
    #1;
    chk("sim_pop63", pop_num[0], 63);
    step();
    idle();
    chk("sim_count", count, 1);
    chk("sim_no_uf", err_underflow, 0);
    pop = 2'b01;
    #1;
    chk("sim_pop5", pop_num[0], 5);
    step();
    idle();
    chk("sim_count0", count, 0);
    pop = 2'b01;
    push = 2'b01;
    push_num[0] = 6'd9;
    step();
    idle();
    chk("sim0_count", count, 1);
    chk("sim0_under", err_underflow, 1);
    pop = 2'b01;
    #1;
    chk("sim0_pop9", pop_num[0], 9);
    step();
    idle();

    // Overflow
    reset_and_init();
    chk("of_pre_over", err_overflow, 0);
    push = 2'b11;
    push_num[0] = 6'd9;
    push_num[1] = 6'd7;
    step();
    idle();
    chk("of_flag", err_overflow, 1);
    chk("of_count", count, 32);
    chk("of_under", err_underflow, 0);
    pop = 2'b11;
    #1;
    chk("of_lane0", pop_num[0], 32);
    chk("of_lane1", pop_num[1], 33);
    step();
    idle();
    chk("of_sticky", err_overflow, 1);

    // Wrap-around with a FIFO model
    reset_and_init();
    exp_q.delete();
    for (int v = 32; v < 64; v++) exp_q.push_back(6'(v));
    for (int c = 0; c < 100; c++) begin
      e0 = exp_q.pop_front();
      e1 = exp_q.pop_front();
      pop = 2'b11;
      push = 2'b11;
      push_num[0] = e0;
      push_num[1] = e1;
      #1;
      chk("wrap_lane0", pop_num[0], e0);
      chk("wrap_lane1", pop_num[1], e1);
      exp_q.push_back(e0);
      exp_q.push_back(e1);
      step();
      chk("wrap_count", count, 32);
    end
    idle();
    chk("wrap_under", err_underflow, 0);
    chk("wrap_over", err_overflow, 0);

    // Reset mid-init
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (5) step();
    pop = 2'b01;
    push = 2'b01;
    step();
    idle();
    chk("mi_count6", count, 6);
    chk("mi_under", err_underflow, 1);
    chk("mi_over", err_overflow, 1);
    repeat (4) step();
    chk("mi_count10", count, 10);
    rst_n = 1'b0;
    #1;
    chk("mi_rst_count", count, 0);
    chk("mi_rst_under", err_underflow, 0);
    chk("mi_rst_over", err_overflow, 0);
    chk("mi_rst_ready", ready, 0);
    step();
    rst_n = 1'b1;
    repeat (31) step();
    chk("mi_ready_lo", ready, 0);
    step();
    chk("mi_ready_hi", ready, 1);
    chk("mi_count32", count, 32);
    pop = 2'b01;
    #1;
    chk("mi_pop32", pop_num[0], 32);
    step();
    idle();

`ifdef RSD_FREE_LIST_DUP_CHECK_EN
    // head now at 33, count 31; 40 is still free
    push = 2'b01;
    push_num[0] = 6'd40;
    step();
    idle();
    chk("dup_flag", err_dup, 1);
    chk("dup_count", count, 31);
    chk("dup_no_of", err_overflow, 0);
    push = 2'b11;
    push_num[0] = 6'd32;
    push_num[1] = 6'd32;
    step();
    idle();
    chk("dup_lane_count", count, 32);
    chk("dup_lane_of", err_overflow, 0);
`else
    push = 2'b01;
    push_num[0] = 6'd40;
    step();
    idle();
    chk("nodup_flag", err_dup, 0);
    chk("nodup_count", count, 32);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
